// File: rtl/spi_master_pkg.sv
// Shared encodings for the multi-chip-select SPI master: FSM states and {cpol,cpha} mode constants.
package spi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing: CLK_DIV-cycle half-period tick, leading/trailing edge strobes and the registered SCLK pin.
// Zero-latency strobes, SCLK registered one cycle after the tick; no backpressure (free-running while enabled).
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic xfer,
    input  logic odd,
    input  logic cpol,
    output logic tick,
    output logic lead,
    output logic trail,
    output logic spi_sclk
);

    localparam int CW = $clog2(CLK_DIV) | 1;

    logic [CW-1:0] cnt;

    assign tick  = en && (cnt == CW'(CLK_DIV - 1));
    // Even bit_cnt values map to odd-numbered toggles, i.e. the leading edge.
    assign lead  = tick && xfer && !odd;
    assign trail = tick && xfer && odd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            spi_sclk <= 1'b0;
        end else begin
            if (!en || tick) cnt <= '0;
            else             cnt <= cnt + CW'(1);

            if (!xfer)     spi_sclk <= cpol;
            else if (tick) spi_sclk <= ~spi_sclk;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// Full-duplex SPI master, any width, modes 0-3, NUM_CS selects; SPI_LSB_FIRST_EN adds an lsb_first input.
// Latency: done CLK_DIV*(2*DATA_WIDTH+2) cycles after accept; one command at a time, cmd_ready low while busy.
module spi_master_multi
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CS     = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cpol,
    input  logic                            cpha,
    input  logic [($clog2(NUM_CS) | 1)-1:0] cs_sel,
    input  logic [DATA_WIDTH-1:0]           tx_data,
    output logic [DATA_WIDTH-1:0]           rx_data,
    output logic                            done,
    output logic                            busy,
    output logic                            spi_sclk,
    output logic                            spi_mosi,
    input  logic                            spi_miso,
`ifdef SPI_LSB_FIRST_EN
    input  logic                            lsb_first,
`endif
    output logic [NUM_CS-1:0]               spi_cs_n
);

    localparam int CSW = $clog2(NUM_CS) | 1;
    localparam int BW  = $clog2(2 * DATA_WIDTH);

    state_t                state, nxt;
    logic                  en, xfer, tick, lead, trail;
    logic                  accept, sample, drive, fin, last_bit;
    logic                  cpol_q, cpha_q, lsb_q, lsb_in, cpol_eff;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
    logic [NUM_CS-1:0]     cs_dec;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (accept)            nxt = ST_SETUP;
            ST_SETUP: if (tick)              nxt = ST_XFER;
            ST_XFER:  if (tick && last_bit)  nxt = ST_HOLD;
            ST_HOLD:  if (tick)              nxt = ST_IDLE;
            default:                         nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        en        = 1'b1;
        xfer      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !done;
                busy      = done;
                en        = 1'b0;
            end
            ST_XFER: xfer = 1'b1;
            default: ;
        endcase
    end

    assign accept   = cmd_valid && cmd_ready;
    assign cpol_eff = en ? cpol_q : cpol;
    assign last_bit = (bit_cnt == BW'(2 * DATA_WIDTH - 1));
    assign sample   = cpha_q ? trail : lead;
    assign drive    = cpha_q ? lead : (trail && !last_bit);
    assign fin      = (state == ST_HOLD) && tick;

    // Out-of-range selects leave every chip select deasserted.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
    end

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .xfer     (xfer),
        .odd      (bit_cnt[0]),
        .cpol     (cpol_eff),
        .tick     (tick),
        .lead     (lead),
        .trail    (trail),
        .spi_sclk (spi_sclk)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            done     <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= '1;
            bit_cnt  <= '0;
        end else begin
            done <= fin;
            if (accept) begin
                cpol_q   <= cpol;
                cpha_q   <= cpha;
                lsb_q    <= lsb_in;
                spi_cs_n <= cs_dec;
                // cpha=0 needs the first bit on the wire before the first edge.
                if (!cpha) begin
                    spi_mosi <= first_bit(tx_data, lsb_in);
                    tx_sr    <= advance(tx_data, lsb_in);
                end else begin
                    tx_sr    <= tx_data;
                end
            end
            if (drive) begin
                spi_mosi <= first_bit(tx_sr, lsb_q);
                tx_sr    <= advance(tx_sr, lsb_q);
            end
            if (sample)
                rx_sr <= lsb_q ? {spi_miso, rx_sr[DATA_WIDTH-1:1]}
                               : {rx_sr[DATA_WIDTH-2:0], spi_miso};
            if (state != ST_XFER)       bit_cnt <= '0;
            else if (tick && !last_bit) bit_cnt <= bit_cnt + BW'(1);
            if (fin) begin
                rx_data  <= rx_sr;
                spi_cs_n <= '1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: modes 0-3, CS decode, back-to-back, mid-transfer reset, optional LSB-first.
`timescale 1ns/1ps
module tb_spi_master_multi;
    import spi_master_pkg::*;

    localparam int DW     = 32;
    localparam int NCS    = 4;
    localparam int DIV    = 4;
    localparam int T_DONE = DIV * (2 * DW + 2);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic [2:0]     cs_sel = 3'd0;
    logic [DW-1:0]  tx_data = '0;
    logic [DW-1:0]  rx_data;
    logic           done, busy, spi_sclk, spi_mosi, spi_miso;
    logic [NCS-1:0] spi_cs_n;
    logic           lsb_first_v = 1'b0;

    int errors = 0;
    int checks = 0;

    logic          use_model = 1'b0;
    logic          m_cpol = 1'b0;
    logic          m_cpha = 1'b0;
    logic [DW-1:0] slv_word = '0;
    logic          miso_m = 1'b0;
    logic          sclk_q = 1'b0;
    logic [DW-1:0] slv_tx = '0;
    logic [DW-1:0] slv_rx = '0;
    int            slv_bits = 0;
    int            tog = 0;

    always #5 clk = ~clk;

    assign spi_miso = use_model ? miso_m : spi_mosi;

    spi_master_multi #(.DATA_WIDTH(DW), .NUM_CS(NCS), .CLK_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cpol      (cpol),
        .cpha      (cpha),
        .cs_sel    (cs_sel),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .done      (done),
        .busy      (busy),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_first_v),
`endif
        .spi_cs_n  (spi_cs_n)
    );

    always @(spi_sclk) tog++;

    // Slave model: captures MOSI MSB-first on its sample edge, drives slv_word MSB-first on the other edge.
    always @(spi_sclk or spi_cs_n) begin
        if (spi_cs_n == '1) begin
            slv_tx = slv_word;
        end else if (spi_sclk !== sclk_q) begin
            if ((spi_sclk ^ m_cpol) ^ m_cpha) begin
                slv_rx = {slv_rx[DW-2:0], spi_mosi};
                slv_bits++;
            end else begin
                miso_m = slv_tx[DW-1];
                slv_tx = slv_tx << 1;
            end
        end
        sclk_q = spi_sclk;
    end

    // Issues one command at a negedge and follows it to the done cycle, tallying protocol anomalies.
    task automatic run_xfer(input logic pol, input logic pha, input logic [2:0] sel,
                            input logic [DW-1:0] tx, input logic [NCS-1:0] exp_cs, input logic keep,
                            output logic rdy0, output int lat, output int cs_bad,
                            output int hs_bad, output int mosi_bad);
        logic pm, ps;
        cpol = pol; cpha = pha; cs_sel = sel; tx_data = tx; cmd_valid = 1'b1;
        rdy0 = cmd_ready;
        pm = spi_mosi; ps = spi_sclk;
        lat = 0; cs_bad = 0; hs_bad = 0; mosi_bad = 0;
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        while (done !== 1'b1 && lat < 4 * T_DONE) begin
            if (spi_cs_n !== exp_cs) cs_bad++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) hs_bad++;
            if (spi_mosi !== pm && !(ps === 1'b1 && spi_sclk === 1'b0)) mosi_bad++;
            pm = spi_mosi; ps = spi_sclk;
            @(negedge clk);
            lat++;
        end
        if (spi_cs_n !== '1) cs_bad++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) hs_bad++;
        if (spi_mosi !== pm && !(ps === 1'b1 && spi_sclk === 1'b0)) mosi_bad++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data: got %h want 0", rx_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        checks++; if (spi_cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs_n: got %b want 1111", spi_cs_n); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        logic rdy0;
        int lat, csb, hsb, mb, t0;
        use_model = 1'b0; m_cpol = SPI_MODE0[1]; m_cpha = SPI_MODE0[0];
        t0 = tog;
        run_xfer(SPI_MODE0[1], SPI_MODE0[0], 3'd0, 32'hA5A5_F00F, 4'b1110, 1'b0, rdy0, lat, csb, hsb, mb);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL m0_ready_before: got %b want 1", rdy0); end
        checks++; if (lat != T_DONE) begin errors++; $display("FAIL m0_latency: got %0d want %0d", lat, T_DONE); end
        checks++; if (tog - t0 != 2 * DW) begin errors++; $display("FAIL m0_toggles: got %0d want %0d", tog - t0, 2 * DW); end
        checks++; if (rx_data !== 32'hA5A5_F00F) begin errors++; $display("FAIL m0_rx: got %h want a5a5f00f", rx_data); end
        checks++; if (slv_rx !== 32'hA5A5_F00F) begin errors++; $display("FAIL m0_mosi_word: got %h want a5a5f00f", slv_rx); end
        checks++; if (csb != 0) begin errors++; $display("FAIL m0_cs: got %0d bad cycles want 0", csb); end
        checks++; if (hsb != 0) begin errors++; $display("FAIL m0_busy_ready: got %0d bad cycles want 0", hsb); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL m0_done_pulse: got %b want 0", done); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL m0_after_done: got busy=%b ready=%b want busy=0 ready=1", busy, cmd_ready); end
    endtask

    task automatic test_mode3();
        logic rdy0;
        int lat, csb, hsb, mb, b0;
        cpol = SPI_MODE3[1]; cpha = SPI_MODE3[0];
        m_cpol = SPI_MODE3[1]; m_cpha = SPI_MODE3[0];
        slv_word = 32'h1234_5678; use_model = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (spi_sclk !== 1'b1) begin errors++; $display("FAIL m3_idle_sclk: got %b want 1", spi_sclk); end
        b0 = slv_bits;
        run_xfer(SPI_MODE3[1], SPI_MODE3[0], 3'd0, 32'h8000_0001, 4'b1110, 1'b0, rdy0, lat, csb, hsb, mb);
        checks++; if (rx_data !== 32'h1234_5678) begin errors++; $display("FAIL m3_rx: got %h want 12345678", rx_data); end
        checks++; if (slv_rx !== 32'h8000_0001) begin errors++; $display("FAIL m3_mosi_word: got %h want 80000001", slv_rx); end
        checks++; if (slv_bits - b0 != DW) begin errors++; $display("FAIL m3_bits: got %0d want %0d", slv_bits - b0, DW); end
        checks++; if (mb != 0) begin errors++; $display("FAIL m3_mosi_on_fall: got %0d bad changes want 0", mb); end
        checks++; if (lat != T_DONE) begin errors++; $display("FAIL m3_latency: got %0d want %0d", lat, T_DONE); end
        @(negedge clk);
        checks++; if (spi_sclk !== 1'b1) begin errors++; $display("FAIL m3_idle_after: got %b want 1", spi_sclk); end
        use_model = 1'b0;
    endtask

    task automatic test_cs();
        logic rdy0;
        int lat, csb, hsb, mb;
        cpol = SPI_MODE1[1]; cpha = SPI_MODE1[0];
        m_cpol = SPI_MODE1[1]; m_cpha = SPI_MODE1[0];
        repeat (2) @(negedge clk);
        checks++; if (spi_cs_n !== 4'hF) begin errors++; $display("FAIL cs_idle: got %b want 1111", spi_cs_n); end
        run_xfer(SPI_MODE1[1], SPI_MODE1[0], 3'd2, 32'h3C96_0FF1, 4'b1011, 1'b0, rdy0, lat, csb, hsb, mb);
        checks++; if (csb != 0) begin errors++; $display("FAIL cs2_pattern: got %0d bad cycles want 0", csb); end
        checks++; if (rx_data !== 32'h3C96_0FF1) begin errors++; $display("FAIL cs2_rx: got %h want 3c960ff1", rx_data); end
        @(negedge clk);
        cpol = SPI_MODE2[1]; cpha = SPI_MODE2[0];
        m_cpol = SPI_MODE2[1]; m_cpha = SPI_MODE2[0];
        repeat (2) @(negedge clk);
        run_xfer(SPI_MODE2[1], SPI_MODE2[0], 3'd5, 32'h5A0F_C3E1, 4'hF, 1'b0, rdy0, lat, csb, hsb, mb);
        checks++; if (csb != 0) begin errors++; $display("FAIL cs5_all_high: got %0d bad cycles want 0", csb); end
        checks++; if (rx_data !== 32'h5A0F_C3E1) begin errors++; $display("FAIL cs5_rx: got %h want 5a0fc3e1", rx_data); end
        checks++; if (lat != T_DONE) begin errors++; $display("FAIL cs5_latency: got %0d want %0d", lat, T_DONE); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic rdy0;
        int lat, csb, hsb, mb, t0;
        cpol = 1'b0; cpha = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0;
        repeat (2) @(negedge clk);
        t0 = tog;
        run_xfer(1'b0, 1'b0, 3'd0, 32'hDEAD_BEEF, 4'b1110, 1'b1, rdy0, lat, csb, hsb, mb);
        checks++; if (rx_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rx1: got %h want deadbeef", rx_data); end
        checks++; if (hsb != 0) begin errors++; $display("FAIL b2b_ready_low: got %0d bad cycles want 0", hsb); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: got ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy); end
        run_xfer(1'b0, 1'b0, 3'd0, 32'h0123_4567, 4'b1110, 1'b0, rdy0, lat, csb, hsb, mb);
        checks++; if (lat != T_DONE) begin errors++; $display("FAIL b2b_second_accept: got %0d want %0d", lat, T_DONE); end
        checks++; if (rx_data !== 32'h0123_4567) begin errors++; $display("FAIL b2b_rx2: got %h want 01234567", rx_data); end
        checks++; if (tog - t0 != 4 * DW) begin errors++; $display("FAIL b2b_toggles: got %0d want %0d", tog - t0, 4 * DW); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic rdy0;
        int lat, csb, hsb, mb;
        cpol = 1'b0; cpha = 1'b0; cs_sel = 3'd1; tx_data = 32'hFFFF_FFFF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (DIV + 2 * 10 * DIV) @(negedge clk);
        checks++; if (busy !== 1'b1 || spi_cs_n !== 4'b1101) begin
            errors++; $display("FAIL rm_active: got busy=%b cs_n=%b want busy=1 cs_n=1101", busy, spi_cs_n); end
        rst = 1'b0;
        #1;
        checks++; if (spi_cs_n !== 4'hF) begin errors++; $display("FAIL rm_cs_n: got %b want 1111", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rm_sclk: got %b want 0", spi_sclk); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rm_busy_done: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", cmd_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_xfer(1'b0, 1'b0, 3'd1, 32'h600D_F00D, 4'b1101, 1'b0, rdy0, lat, csb, hsb, mb);
        checks++; if (rx_data !== 32'h600D_F00D) begin errors++; $display("FAIL rm_rx_after: got %h want 600df00d", rx_data); end
        checks++; if (lat != T_DONE || csb != 0) begin
            errors++; $display("FAIL rm_xfer_after: got lat=%0d csbad=%0d want %0d 0", lat, csb, T_DONE); end
        @(negedge clk);
    endtask

`ifdef SPI_LSB_FIRST_EN
    task automatic test_lsb_first();
        logic rdy0;
        int lat, csb, hsb, mb;
        m_cpol = 1'b0; m_cpha = 1'b0; use_model = 1'b0; lsb_first_v = 1'b1;
        run_xfer(1'b0, 1'b0, 3'd0, 32'h0000_0001, 4'b1110, 1'b0, rdy0, lat, csb, hsb, mb);
        checks++; if (slv_rx !== 32'h8000_0000) begin errors++; $display("FAIL lsb_wire: got %h want 80000000", slv_rx); end
        checks++; if (rx_data !== 32'h0000_0001) begin errors++; $display("FAIL lsb_rx: got %h want 00000001", rx_data); end
        lsb_first_v = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_cs();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
